// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings and the bit-period derivation used by
// both the receiver and the transmitter so the two ends always agree.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RECV  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// Line conditioning: 2-flop synchronizer followed by a 3-sample agreement
// filter so single-cycle glitches never reach the receiver FSM.
module uart_rx_filter (
    input  logic clk,
    input  logic resetn,
    input  logic uart_rxd,
    output logic rxd_f
);

    logic       sync1;
    logic       sync2;
    logic [1:0] hist;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 2'b11;
            rxd_f <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            sync2 <= sync1;
            hist  <= {hist[0], sync2};
            if (sync2 == hist[0] && hist[0] == hist[1])
                rxd_f <= sync2;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: recovers start/data/stop frames from the conditioned line and
// reports each one as exactly one of valid, break or framing-error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50000000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_break,
    output logic                    uart_rx_ferr
);

    localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
    localparam int IDX_W          = $clog2(PAYLOAD_BITS + 1);

    if (STOP_BITS < 1) begin : g_bad_stop_bits
        $error("uart_rx: STOP_BITS must be at least 1");
    end

    uart_state_t             state, state_nx;
    logic [CNT_W-1:0]        cyc_cnt;
    logic [IDX_W-1:0]        bit_idx;
    logic [PAYLOAD_BITS-1:0] sreg;
    logic                    rxd_f;
    logic                    rxd_prev;

    logic fall, half_hit, bit_hit, last_bit;
    logic cnt_clr, shift_en, stop_smp;

    uart_rx_filter u_filter (
        .clk      (clk),
        .resetn   (resetn),
        .uart_rxd (uart_rxd),
        .rxd_f    (rxd_f)
    );

    assign fall     = rxd_prev & ~rxd_f;
    assign half_hit = (cyc_cnt == CNT_W'(HALF_BIT));
    assign bit_hit  = (cyc_cnt == CNT_W'(CYCLES_PER_BIT - 1));
    assign last_bit = (bit_idx == IDX_W'(PAYLOAD_BITS - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nx;
    end

    // Dropping the enable abandons any frame in flight on the next cycle.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (uart_rx_en && fall) state_nx = ST_START;
            ST_START: if (!uart_rx_en)        state_nx = ST_IDLE;
                      else if (half_hit)      state_nx = rxd_f ? ST_IDLE : ST_RECV;
            ST_RECV:  if (!uart_rx_en)        state_nx = ST_IDLE;
                      else if (bit_hit && last_bit) state_nx = ST_STOP;
            ST_STOP:  if (!uart_rx_en || bit_hit) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_clr  = (state_nx != state) || (state == ST_IDLE) || (state == ST_RECV && bit_hit);
        shift_en = (state == ST_RECV) && uart_rx_en && bit_hit;
        stop_smp = (state == ST_STOP) && uart_rx_en && bit_hit;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cyc_cnt  <= '0;
            bit_idx  <= '0;
            sreg     <= '0;
            rxd_prev <= 1'b1;
        end else begin
            rxd_prev <= rxd_f;
            cyc_cnt  <= cnt_clr ? '0 : cyc_cnt + 1'b1;
            if (state != ST_RECV) bit_idx <= '0;
            else if (shift_en)    bit_idx <= bit_idx + 1'b1;
            if (shift_en) sreg <= {rxd_f, sreg[PAYLOAD_BITS-1:1]};
        end
    end

    // Stop-bit sample picks exactly one of the three status pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
            uart_rx_ferr  <= 1'b0;
            uart_rx_data  <= '0;
        end else begin
            uart_rx_valid <= stop_smp && rxd_f;
            uart_rx_break <= stop_smp && !rxd_f && (sreg == '0);
            uart_rx_ferr  <= stop_smp && !rxd_f && (sreg != '0);
            if (stop_smp && rxd_f) uart_rx_data <= sreg;
        end
    end

endmodule
